// File: rtl/block_killer_pkg.sv
// Shared constants, state encoding and board indexing for the tile game engine.
package block_killer_pkg;

    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_BLUE  = 3'b001;

    localparam int CELL_W = 3;
    localparam int ROWS   = 8;
    localparam int COLS   = 4;
    localparam int COL_W  = CELL_W * ROWS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    // LSB index of a cell in the flattened board; column n occupies [n*COL_W +: COL_W],
    // row 0 is the top cell at the MSB end of the column.
    function automatic int cell_at(input int col, input int row);
        return col * COL_W + (ROWS - 1 - row) * CELL_W;
    endfunction

endpackage

// File: rtl/lfsr8_rand.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) exposing its low bits as a random pick.
module lfsr8_rand #(
    parameter logic [7:0] SEED  = 8'hA5,
    parameter int         OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [OUT_W-1:0] rand_bits
);

    logic [7:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

    assign rand_bits = q[OUT_W-1:0];

endmodule

// File: rtl/tile_board_writer.sv
// Tile game engine: scrolls the board, inserts random tiles, clears hits, scores.
// Optional `BLOCK_SPEEDUP_EN shortens the scroll period as the score climbs.
module tile_board_writer
    import block_killer_pkg::*;
#(
    parameter int         TICK_CYCLES = 25_000_000,
    parameter logic [2:0] TILE_COLOR  = COLOR_BLUE,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         MIN_TICK    = 6_250_000
) (
    input  logic        CLK_50M,
    input  logic        RST_N,
    input  logic        start,
    input  logic [3:0]  key_hit,
    output logic [23:0] column_0,
    output logic [23:0] column_1,
    output logic [23:0] column_2,
    output logic [23:0] column_3,
    output logic [7:0]  score,
    output logic        game_over,
    output logic        playing
);

    localparam logic [31:0] PERIOD_INIT  = 32'(TICK_CYCLES);
    localparam logic [31:0] PERIOD_FLOOR = (32'(MIN_TICK) < PERIOD_INIT) ? 32'(MIN_TICK) : PERIOD_INIT;

    state_t                   state, state_next;
    logic [31:0]              tick_cnt, cnt_next;
    logic [31:0]              period;
    logic [COLS*COL_W-1:0]    board, board_next, board_hit;
    logic [7:0]               score_next, score_hit;
    logic [1:0]               lfsr_pick;
    logic                     key_onehot, wrong_key, bottom_full, tick;

    lfsr8_rand #(
        .SEED  (LFSR_SEED),
        .OUT_W (2)
    ) u_lfsr (
        .clk       (CLK_50M),
        .rst_n     (RST_N),
        .en        (1'b1),
        .rand_bits (lfsr_pick)
    );

`ifdef BLOCK_SPEEDUP_EN
    localparam logic [31:0] PERIOD_STEP = 32'(TICK_CYCLES / 16);
    logic [31:0] period_next;

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            period <= PERIOD_INIT;
        end else begin
            period <= period_next;
        end
    end
`else
    // The floor can never bind here; the period stays at its initial value.
    assign period = (PERIOD_INIT > PERIOD_FLOOR) ? PERIOD_INIT : PERIOD_FLOOR;
`endif

    assign key_onehot = (key_hit != 4'd0) && ((key_hit & (key_hit - 4'd1)) == 4'd0);

    always_comb begin
        state_next  = state;
        cnt_next    = tick_cnt;
        board_next  = board;
        score_next  = score;
        board_hit   = board;
        score_hit   = score;
        wrong_key   = 1'b0;
        bottom_full = 1'b0;
        tick        = 1'b0;
`ifdef BLOCK_SPEEDUP_EN
        period_next = period;
`endif

        case (state)
            RUN: begin
                // >= keeps the tick reachable if the period shrinks below the running count.
                tick = (tick_cnt >= period - 32'd1);
                if (key_onehot) begin
                    for (int n = 0; n < COLS; n++) begin
                        if (key_hit[n]) begin
                            if (board[cell_at(n, ROWS-1) +: CELL_W] != 3'b000) begin
                                board_hit[cell_at(n, ROWS-1) +: CELL_W] = 3'b000;
                                if (score != 8'hFF) begin
                                    score_hit = score + 8'd1;
                                end
                            end else begin
                                wrong_key = 1'b1;
                            end
                        end
                    end
                end
                for (int n = 0; n < COLS; n++) begin
                    if (board_hit[cell_at(n, ROWS-1) +: CELL_W] != 3'b000) begin
                        bottom_full = 1'b1;
                    end
                end

                if (wrong_key) begin
                    state_next = OVER;
                    cnt_next   = '0;
                end else begin
                    board_next = board_hit;
                    score_next = score_hit;
`ifdef BLOCK_SPEEDUP_EN
                    if (score_hit != score && score_hit[2:0] == 3'b000) begin
                        period_next = (period < PERIOD_FLOOR + PERIOD_STEP) ? PERIOD_FLOOR
                                                                             : period - PERIOD_STEP;
                    end
`endif
                    if (!tick) begin
                        cnt_next = tick_cnt + 32'd1;
                    end else begin
                        cnt_next = '0;
                        if (bottom_full) begin
                            state_next = OVER;
                        end else begin
                            for (int n = 0; n < COLS; n++) begin
                                board_next[n*COL_W +: COL_W] =
                                    {(lfsr_pick == 2'(n)) ? TILE_COLOR : 3'b000,
                                     board_hit[n*COL_W + CELL_W +: COL_W - CELL_W]};
                            end
                        end
                    end
                end
            end
            default: begin
                cnt_next = '0;
            end
        endcase

        if (start) begin
            state_next = RUN;
            cnt_next   = '0;
            board_next = '0;
            score_next = '0;
`ifdef BLOCK_SPEEDUP_EN
            period_next = PERIOD_INIT;
`endif
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            board     <= '0;
            score     <= '0;
            game_over <= 1'b0;
            playing   <= 1'b0;
        end else begin
            state     <= state_next;
            tick_cnt  <= cnt_next;
            board     <= board_next;
            score     <= score_next;
            game_over <= (state_next == OVER);
            playing   <= (state_next == RUN);
        end
    end

    assign column_0 = board[0*COL_W +: COL_W];
    assign column_1 = board[1*COL_W +: COL_W];
    assign column_2 = board[2*COL_W +: COL_W];
    assign column_3 = board[3*COL_W +: COL_W];

endmodule

// File: tb/tb_tile_board_writer.sv
// Directed bench for tile_board_writer with a short scroll period and a tile-position model.
module tb_tile_board_writer;

    localparam int         TICK = 16;
    localparam logic [2:0] TCOL = 3'b101;
    localparam logic [7:0] SEED = 8'hA5;
    localparam int         MIN  = 12;

    logic        CLK_50M = 1'b0;
    logic        RST_N   = 1'b0;
    logic        start   = 1'b0;
    logic [3:0]  key_hit = 4'd0;
    logic [23:0] column_0, column_1, column_2, column_3;
    logic [7:0]  score;
    logic        game_over, playing;
    logic [23:0] dut_col [4];

    int tests = 0;
    int fails = 0;

    // Model: which column holds the tile of each row, game state 0 idle / 1 run / 2 over.
    logic [7:0] m_lfsr;
    logic [1:0] m_col [8];
    logic       m_val [8];
    logic [7:0] m_score;
    int         m_cnt, m_period, m_state;
    logic [1:0] first_c;

    tile_board_writer #(
        .TICK_CYCLES (TICK),
        .TILE_COLOR  (TCOL),
        .LFSR_SEED   (SEED),
        .MIN_TICK    (MIN)
    ) dut (
        .CLK_50M   (CLK_50M),
        .RST_N     (RST_N),
        .start     (start),
        .key_hit   (key_hit),
        .column_0  (column_0),
        .column_1  (column_1),
        .column_2  (column_2),
        .column_3  (column_3),
        .score     (score),
        .game_over (game_over),
        .playing   (playing)
    );

    assign dut_col[0] = column_0;
    assign dut_col[1] = column_1;
    assign dut_col[2] = column_2;
    assign dut_col[3] = column_3;

    always #5 CLK_50M = ~CLK_50M;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [23:0] exp_col(input int n);
        logic [23:0] v;
        v = '0;
        for (int r = 0; r < 8; r++) begin
            if (m_val[r] && m_col[r] == 2'(n)) v[23-3*r -: 3] = TCOL;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_lfsr   = SEED;
        m_score  = 8'd0;
        m_cnt    = 0;
        m_period = TICK;
        m_state  = 0;
        for (int r = 0; r < 8; r++) begin
            m_val[r] = 1'b0;
            m_col[r] = 2'd0;
        end
    endtask

    // One clock: drive inputs, advance the model across the posedge, return at the negedge.
    task automatic step(input logic [3:0] k, input logic s);
        logic [1:0] pick;
        logic       tk, wrong, onehot;
        int         idx;
        key_hit = k;
        start   = s;
        @(posedge CLK_50M);
        pick   = m_lfsr[1:0];
        m_lfsr = lfsr_next(m_lfsr);
        if (s) begin
            for (int r = 0; r < 8; r++) m_val[r] = 1'b0;
            m_score  = 8'd0;
            m_cnt    = 0;
            m_period = TICK;
            m_state  = 1;
        end else if (m_state == 1) begin
            tk     = (m_cnt >= m_period - 1);
            onehot = (k != 4'd0) && ((k & (k - 4'd1)) == 4'd0);
            wrong  = 1'b0;
            if (onehot) begin
                idx = 0;
                for (int n = 0; n < 4; n++) if (k[n]) idx = n;
                if (m_val[7] && m_col[7] == 2'(idx)) begin
                    m_val[7] = 1'b0;
                    if (m_score != 8'hFF) begin
                        m_score = m_score + 8'd1;
`ifdef BLOCK_SPEEDUP_EN
                        if (m_score[2:0] == 3'b000)
                            m_period = (m_period - TICK/16 < MIN) ? MIN : m_period - TICK/16;
`endif
                    end
                end else begin
                    wrong = 1'b1;
                end
            end
            if (wrong) begin
                m_state = 2;
                m_cnt   = 0;
            end else if (tk) begin
                m_cnt = 0;
                if (m_val[7]) begin
                    m_state = 2;
                end else begin
                    for (int r = 7; r > 0; r--) begin
                        m_val[r] = m_val[r-1];
                        m_col[r] = m_col[r-1];
                    end
                    m_val[0] = 1'b1;
                    m_col[0] = pick;
                end
            end else begin
                m_cnt++;
            end
        end
        @(negedge CLK_50M);
        key_hit = 4'd0;
        start   = 1'b0;
    endtask

    task automatic test_reset();
        logic bad;
        RST_N = 1'b0;
        #2;
        bad = 1'b0;
        for (int n = 0; n < 4; n++) if (dut_col[n] !== 24'h0) bad = 1'b1;
        tests++;
        if (bad) begin
            fails++;
            $display("[TB] FAIL reset_columns: got %h %h %h %h required all 0", column_0, column_1, column_2, column_3);
        end
        tests++;
        if (score !== 8'd0) begin fails++; $display("[TB] FAIL reset_score: got %0d required 0", score); end
        tests++;
        if (game_over !== 1'b0 || playing !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_flags: got over=%b playing=%b required 0 0", game_over, playing);
        end
        @(negedge CLK_50M);
        @(negedge CLK_50M);
        RST_N = 1'b1;
        model_reset();
        step(4'b0001, 1'b0);
        tests++;
        if (game_over !== 1'b0 || playing !== 1'b0) begin
            fails++;
            $display("[TB] FAIL idle_ignores_key: got over=%b playing=%b required 0 0", game_over, playing);
        end
    endtask

    task automatic test_first_tile();
        logic bad;
        step(4'd0, 1'b1);
        tests++;
        if (playing !== 1'b1 || column_0 !== 24'h0 || column_1 !== 24'h0) begin
            fails++;
            $display("[TB] FAIL start_run: got playing=%b c0=%h c1=%h required 1 0 0", playing, column_0, column_1);
        end
        repeat (TICK - 1) step(4'd0, 1'b0);
        bad = 1'b0;
        for (int n = 0; n < 4; n++) if (dut_col[n] !== 24'h0) bad = 1'b1;
        tests++;
        if (bad) begin
            fails++;
            $display("[TB] FAIL pre_tick_empty: got %h %h %h %h required all 0", column_0, column_1, column_2, column_3);
        end
        first_c = m_lfsr[1:0];
        step(4'd0, 1'b0);
        tests++;
        if (dut_col[first_c][23:21] !== TCOL) begin
            fails++;
            $display("[TB] FAIL first_tile: got %b in column %0d top required %b", dut_col[first_c][23:21], first_c, TCOL);
        end
        bad = 1'b0;
        for (int n = 0; n < 4; n++) if (dut_col[n] !== exp_col(n)) bad = 1'b1;
        tests++;
        if (bad) begin
            fails++;
            $display("[TB] FAIL first_tick_board: got %h %h %h %h required %h %h %h %h", column_0, column_1, column_2, column_3, exp_col(0), exp_col(1), exp_col(2), exp_col(3));
        end
    endtask

    task automatic test_miss();
        logic bad;
        repeat (7 * TICK) step(4'd0, 1'b0);
        tests++;
        if (dut_col[first_c][2:0] !== TCOL || playing !== 1'b1) begin
            fails++;
            $display("[TB] FAIL tile_at_bottom: got %b playing=%b required %b 1", dut_col[first_c][2:0], playing, TCOL);
        end
        repeat (TICK) step(4'd0, 1'b0);
        tests++;
        if (game_over !== 1'b1 || playing !== 1'b0) begin
            fails++;
            $display("[TB] FAIL miss_over: got over=%b playing=%b required 1 0", game_over, playing);
        end
        bad = 1'b0;
        for (int n = 0; n < 4; n++) if (dut_col[n] !== exp_col(n)) bad = 1'b1;
        tests++;
        if (bad || dut_col[first_c][2:0] !== TCOL) begin
            fails++;
            $display("[TB] FAIL miss_frozen: got %h %h %h %h required %h %h %h %h", column_0, column_1, column_2, column_3, exp_col(0), exp_col(1), exp_col(2), exp_col(3));
        end
        repeat (4) step(4'b0001 << first_c, 1'b0);
        tests++;
        if (game_over !== 1'b1 || score !== 8'd0) begin
            fails++;
            $display("[TB] FAIL over_ignores_key: got over=%b score=%0d required 1 0", game_over, score);
        end
    endtask

    task automatic test_multi_hot_and_wrong_key();
        logic bad;
        step(4'd0, 1'b1);
        repeat (2 * TICK) step(4'd0, 1'b0);
        step(4'b0011, 1'b0);
        bad = 1'b0;
        for (int n = 0; n < 4; n++) if (dut_col[n] !== exp_col(n)) bad = 1'b1;
        tests++;
        if (bad || playing !== 1'b1 || score !== 8'd0) begin
            fails++;
            $display("[TB] FAIL multi_hot_ignored: got %h %h %h %h playing=%b score=%0d", column_0, column_1, column_2, column_3, playing, score);
        end
        step(4'b0001, 1'b0);
        tests++;
        if (game_over !== 1'b1 || playing !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wrong_key_over: got over=%b playing=%b required 1 0", game_over, playing);
        end
        repeat (TICK + 4) step(4'd0, 1'b0);
        bad = 1'b0;
        for (int n = 0; n < 4; n++) if (dut_col[n] !== exp_col(n)) bad = 1'b1;
        tests++;
        if (bad || score !== 8'd0) begin
            fails++;
            $display("[TB] FAIL wrong_key_frozen: got %h %h %h %h score=%0d required %h %h %h %h 0", column_0, column_1, column_2, column_3, score, exp_col(0), exp_col(1), exp_col(2), exp_col(3));
        end
    endtask

    task automatic test_clear_col2();
        logic       bad, found;
        logic [7:0] s0;
        int         w;
        found = 1'b0;
        step(4'd0, 1'b1);
        for (int i = 0; i < 64 * TICK && !found && m_state == 1; i++) begin
            if (m_val[7] && m_cnt == 3) begin
                if (m_col[7] == 2'd2) begin
                    s0 = m_score;
                    step(4'b0100, 1'b0);
                    tests++;
                    if (column_2[2:0] !== 3'b000 || score !== s0 + 8'd1) begin
                        fails++;
                        $display("[TB] FAIL col2_clear: got cell=%b score=%0d required 000 %0d", column_2[2:0], score, s0 + 8'd1);
                    end
                    w = 0;
                    while (m_cnt != 0 && w < 2 * TICK) begin step(4'd0, 1'b0); w++; end
                    bad = 1'b0;
                    for (int n = 0; n < 4; n++) if (dut_col[n] !== exp_col(n)) bad = 1'b1;
                    tests++;
                    if (bad || playing !== 1'b1 || game_over !== 1'b0) begin
                        fails++;
                        $display("[TB] FAIL col2_next_tick: got %h %h %h %h playing=%b required %h %h %h %h 1", column_0, column_1, column_2, column_3, playing, exp_col(0), exp_col(1), exp_col(2), exp_col(3));
                    end
                    found = 1'b1;
                end else begin
                    step(4'b0001 << m_col[7], 1'b0);
                end
            end else begin
                step(4'd0, 1'b0);
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("[TB] FAIL col2_search: got no column-2 bottom tile within bound required one");
        end
    endtask

    task automatic test_hit_on_tick();
        logic       bad, found;
        logic [7:0] s0;
        logic [1:0] pick;
        found = 1'b0;
        for (int i = 0; i < 64 * TICK && !found && m_state == 1; i++) begin
            if (m_val[7] && m_col[7] == 2'd1 && m_cnt >= m_period - 1) begin
                s0   = m_score;
                pick = m_lfsr[1:0];
                step(4'b0010, 1'b0);
                tests++;
                if (game_over !== 1'b0 || playing !== 1'b1 || score !== s0 + 8'd1) begin
                    fails++;
                    $display("[TB] FAIL tick_hit_state: got over=%b playing=%b score=%0d required 0 1 %0d", game_over, playing, score, s0 + 8'd1);
                end
                bad = 1'b0;
                for (int n = 0; n < 4; n++) if (dut_col[n] !== exp_col(n)) bad = 1'b1;
                tests++;
                if (bad || dut_col[pick][23:21] !== TCOL) begin
                    fails++;
                    $display("[TB] FAIL tick_hit_shift: got %h %h %h %h required %h %h %h %h", column_0, column_1, column_2, column_3, exp_col(0), exp_col(1), exp_col(2), exp_col(3));
                end
                found = 1'b1;
            end else if (m_val[7] && m_col[7] != 2'd1 && m_cnt == 3) begin
                step(4'b0001 << m_col[7], 1'b0);
            end else begin
                step(4'd0, 1'b0);
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("[TB] FAIL tick_hit_search: got no column-1 tile on a tick within bound required one");
        end
    endtask

    task automatic test_score_saturation();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 8000 && !done && m_state == 1; i++) begin
            if (m_val[7] && m_cnt == 3) begin
                if (m_score == 8'hFF) begin
                    tests++;
                    if (score !== 8'hFF) begin
                        fails++;
                        $display("[TB] FAIL score_reach_255: got %0d required 255", score);
                    end
                    step(4'b0001 << m_col[7], 1'b0);
                    tests++;
                    if (score !== 8'hFF || playing !== 1'b1) begin
                        fails++;
                        $display("[TB] FAIL score_saturate: got score=%0d playing=%b required 255 1", score, playing);
                    end
                    done = 1'b1;
                end else begin
                    step(4'b0001 << m_col[7], 1'b0);
                end
            end else begin
                step(4'd0, 1'b0);
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL saturation_bound: got score=%0d state=%0d required to reach 255 in RUN", score, m_state);
        end
        step(4'd0, 1'b1);
        tests++;
        if (score !== 8'd0 || playing !== 1'b1 || column_0 !== 24'h0 || column_3 !== 24'h0) begin
            fails++;
            $display("[TB] FAIL restart_in_run: got score=%0d playing=%b c0=%h c3=%h required 0 1 0 0", score, playing, column_0, column_3);
        end
    endtask

    task automatic test_reset_midgame();
        logic bad;
        repeat (3 * TICK) step(4'd0, 1'b0);
        #3;
        RST_N = 1'b0;
        #1;
        bad = 1'b0;
        for (int n = 0; n < 4; n++) if (dut_col[n] !== 24'h0) bad = 1'b1;
        tests++;
        if (bad || score !== 8'd0 || playing !== 1'b0 || game_over !== 1'b0) begin
            fails++;
            $display("[TB] FAIL async_reset: got %h %h %h %h score=%0d playing=%b over=%b required all 0", column_0, column_1, column_2, column_3, score, playing, game_over);
        end
        @(negedge CLK_50M);
        RST_N = 1'b1;
        model_reset();
        step(4'd0, 1'b1);
        repeat (TICK) step(4'd0, 1'b0);
        bad = 1'b0;
        for (int n = 0; n < 4; n++) if (dut_col[n] !== exp_col(n)) bad = 1'b1;
        tests++;
        if (bad) begin
            fails++;
            $display("[TB] FAIL reseed_tile: got %h %h %h %h required %h %h %h %h", column_0, column_1, column_2, column_3, exp_col(0), exp_col(1), exp_col(2), exp_col(3));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_tile();
        test_miss();
        test_multi_hot_and_wrong_key();
        test_clear_col2();
        test_hit_on_tick();
        test_score_saturation();
        test_reset_midgame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
